// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcodes, datapath select codes and the bundled control-word type.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_JAL       = 4'd10,
    ST_ADDI_EXEC = 4'd11,
    ST_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (op == OP_JAL) || (op == OP_ADDI);
  endfunction

  // States whose exit to FETCH completes an instruction.
  function automatic logic is_retire_state(input state_t s);
    return (s == ST_MEM_WB) || (s == ST_MEM_WRITE) || (s == ST_R_WB) || (s == ST_BRANCH) ||
           (s == ST_JUMP) || (s == ST_JAL) || (s == ST_ADDI_WB);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode from the current state, opcode and the
// memory handshake; no state is held here.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl,
  output logic       o_bad_opcode
);

  always_comb begin
    o_ctrl       = '0;
    o_bad_opcode = 1'b0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      ST_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_bad_opcode     = !op_supported(i_opcode);
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = M2R_MDR;
      end
      ST_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        o_ctrl.reg_dst   = REGDST_RD;
        o_ctrl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      // $31 receives the PC already advanced during FETCH.
      ST_JAL: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REGDST_RA;
        o_ctrl.mem_to_reg = M2R_PC;
      end
      ST_ADDI_WB: o_ctrl.reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: state register, next-state sequencing,
// reset gating of every output and the retired-instruction counter.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               bad_opcode,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_retired
);

  state_t               r_state;
  state_t               w_next;
  logic [COUNT_W-1:0]   r_retired;
  ctrl_t                w_ctrl;
  ctrl_t                w_ctrl_out;
  logic                 w_bad;

  mc_ctrl_decode u_decode (
    .i_state      (r_state),
    .i_opcode     (opcode),
    .i_mem_ready  (mem_ready),
    .o_ctrl       (w_ctrl),
    .o_bad_opcode (w_bad)
  );

  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH:     w_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = ST_MEM_ADDR;
          OP_RTYPE:     w_next = ST_R_EXEC;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_J:         w_next = ST_JUMP;
          OP_JAL:       w_next = ST_JAL;
          OP_ADDI:      w_next = ST_ADDI_EXEC;
          default:      w_next = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  w_next = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  w_next = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WRITE: w_next = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_R_EXEC:    w_next = ST_R_WB;
      ST_ADDI_EXEC: w_next = ST_ADDI_WB;
      default:      w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (is_retire_state(r_state) && (w_next == ST_FETCH))
        r_retired <= r_retired + COUNT_W'(1);
    end
  end

  // Reset forces every output low so an aborted instruction writes nothing.
  assign w_ctrl_out    = reset ? '0 : w_ctrl;
  assign bad_opcode    = reset ? 1'b0 : w_bad;
  assign state         = reset ? 4'd0 : r_state;
  assign instr_retired = reset ? '0 : r_retired;

  assign PCWrite     = w_ctrl_out.pc_write;
  assign PCWriteCond = w_ctrl_out.pc_write_cond;
  assign IRWrite     = w_ctrl_out.ir_write;
  assign RegWrite    = w_ctrl_out.reg_write;
  assign MemRead     = w_ctrl_out.mem_read;
  assign MemWrite    = w_ctrl_out.mem_write;
  assign IorD        = w_ctrl_out.i_or_d;
  assign ALUSrcA     = w_ctrl_out.alu_src_a;
  assign ALUSrcB     = w_ctrl_out.alu_src_b;
  assign ALUOp       = w_ctrl_out.alu_op;
  assign PCSource    = w_ctrl_out.pc_source;
  assign RegDst      = w_ctrl_out.reg_dst;
  assign MemtoReg    = w_ctrl_out.mem_to_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected state traces are queued per
// instruction and every cycle's state and control word are checked against them.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;

  logic        PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, IorD, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg;
  logic        bad_opcode;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  logic        w4_PCWrite, w4_PCWriteCond, w4_IRWrite, w4_RegWrite, w4_MemRead, w4_MemWrite;
  logic        w4_IorD, w4_ALUSrcA, w4_bad_opcode;
  logic [1:0]  w4_ALUSrcB, w4_ALUOp, w4_PCSource, w4_RegDst, w4_MemtoReg;
  logic [3:0]  w4_state, w4_instr_retired;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] q_exp_state[$];

  always #5 clk = ~clk;

  multicycle_control #(.COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .bad_opcode(bad_opcode), .state(state),
    .instr_retired(instr_retired)
  );

  multicycle_control #(.COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(w4_PCWrite), .PCWriteCond(w4_PCWriteCond), .IRWrite(w4_IRWrite),
    .RegWrite(w4_RegWrite), .MemRead(w4_MemRead), .MemWrite(w4_MemWrite), .IorD(w4_IorD),
    .ALUSrcA(w4_ALUSrcA), .ALUSrcB(w4_ALUSrcB), .ALUOp(w4_ALUOp), .PCSource(w4_PCSource),
    .RegDst(w4_RegDst), .MemtoReg(w4_MemtoReg), .bad_opcode(w4_bad_opcode),
    .state(w4_state), .instr_retired(w4_instr_retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [17:0] dut_ctrl();
    return {PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, IorD, ALUSrcA,
            ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg};
  endfunction

  // Reference control word, written directly from the state/output table.
  function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic mr);
    logic pcw, pcc, irw, rw, mrd, mwr, iod, sa;
    logic [1:0] sb, aop, pcs, rd, m2r;
    {pcw, pcc, irw, rw, mrd, mwr, iod, sa} = '0;
    {sb, aop, pcs, rd, m2r} = '0;
    case (s)
      4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 2'b01; end
      4'd5:  begin mwr = 1; iod = 1; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rd = 2'b01; rw = 1; end
      4'd8:  begin sa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      4'd11: begin sa = 1; sb = 2'b10; end
      4'd12: rw = 1;
      default: ;
    endcase
    return {pcw, pcc, irw, rw, mrd, mwr, iod, sa, sb, aop, pcs, rd, m2r};
  endfunction

  function automatic logic exp_bad(input logic [3:0] s, input logic [5:0] op);
    if (s != 4'd1) return 1'b0;
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011, 6'b001000: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after the instruction's last cycle.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit abort_mw,
                           output int n_irw, output int n_mwr, output int n_rw);
    bit mrs[$];
    logic [3:0] es;
    bit mr;
    n_irw = 0; n_mwr = 0; n_rw = 0;
    q_exp_state.delete();
    for (int i = 0; i < fw; i++) begin q_exp_state.push_back(4'd0); mrs.push_back(1'b0); end
    q_exp_state.push_back(4'd0); mrs.push_back(1'b1);
    q_exp_state.push_back(4'd1); mrs.push_back(1'($urandom_range(0, 1)));
    case (op)
      6'b100011: begin
        q_exp_state.push_back(4'd2); mrs.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin q_exp_state.push_back(4'd3); mrs.push_back(1'b0); end
        q_exp_state.push_back(4'd3); mrs.push_back(1'b1);
        q_exp_state.push_back(4'd4); mrs.push_back(1'($urandom_range(0, 1)));
      end
      6'b101011: begin
        q_exp_state.push_back(4'd2); mrs.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin q_exp_state.push_back(4'd5); mrs.push_back(1'b0); end
        q_exp_state.push_back(4'd5); mrs.push_back(1'b1);
      end
      6'b000000: begin
        q_exp_state.push_back(4'd6); mrs.push_back(1'b1);
        q_exp_state.push_back(4'd7); mrs.push_back(1'b0);
      end
      6'b000100: begin q_exp_state.push_back(4'd8);  mrs.push_back(1'b1); end
      6'b000010: begin q_exp_state.push_back(4'd9);  mrs.push_back(1'b0); end
      6'b000011: begin q_exp_state.push_back(4'd10); mrs.push_back(1'b1); end
      6'b001000: begin
        q_exp_state.push_back(4'd11); mrs.push_back(1'b1);
        q_exp_state.push_back(4'd12); mrs.push_back(1'b0);
      end
      default: ;
    endcase
    while (q_exp_state.size() > 0) begin
      es = q_exp_state.pop_front();
      mr = mrs.pop_front();
      opcode = op;
      if (abort_mw && es == 4'd5) begin
        reset = 1'b1; mem_ready = 1'b0;
        #1;
        check("abort_ctrl", 32'(dut_ctrl()), 32'd0);
        check("abort_state", 32'(state), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_next_state", 32'(state), 32'd0);
        check("abort_retired", instr_retired, 32'd0);
        check("abort_memwrite_after", 32'(MemWrite), 32'd0);
        q_exp_state.delete();
        @(negedge clk);
        return;
      end
      mem_ready = mr;
      #1;
      check("state", 32'(state), 32'(es));
      check("ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(es, mr)));
      check("bad_opcode", 32'(bad_opcode), 32'(exp_bad(es, op)));
      n_irw += int'(IRWrite);
      n_mwr += int'(MemWrite);
      n_rw  += int'(RegWrite);
      @(negedge clk);
    end
  endtask

  initial begin
    int a, b, c;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_ctrl", 32'(dut_ctrl()), 32'd0);
      check("rst_bad", 32'(bad_opcode), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_retired", instr_retired, 32'd0);
    end
    reset = 1'b0;

    run_instr(6'b000000, 0, 0, 0, a, b, c);
    #1 check("r_retired", instr_retired, 32'd1);
    check("r_regwrite_cycles", 32'(c), 32'd1);

    run_instr(6'b100011, 2, 3, 0, a, b, c);
    #1 check("lw_retired", instr_retired, 32'd2);
    check("lw_irwrite_pulses", 32'(a), 32'd1);

    run_instr(6'b101011, 0, 1, 0, a, b, c);
    #1 check("sw_retired", instr_retired, 32'd3);
    check("sw_memwrite_cycles", 32'(b), 32'd2);
    check("sw_regwrite_cycles", 32'(c), 32'd0);

    run_instr(6'b000100, 1, 0, 0, a, b, c);
    #1 check("beq_retired", instr_retired, 32'd4);
    run_instr(6'b000010, 0, 0, 0, a, b, c);
    #1 check("j_retired", instr_retired, 32'd5);
    check("j_regwrite_cycles", 32'(c), 32'd0);
    run_instr(6'b000011, 0, 0, 0, a, b, c);
    #1 check("jal_retired", instr_retired, 32'd6);
    check("jal_regwrite_cycles", 32'(c), 32'd1);
    run_instr(6'b001000, 0, 0, 0, a, b, c);
    #1 check("addi_retired", instr_retired, 32'd7);

    run_instr(6'b111111, 0, 0, 0, a, b, c);
    #1 check("bad_retired", instr_retired, 32'd7);
    check("bad_back_to_fetch", 32'(state), 32'd0);
    check("w4_retired_7", 32'(w4_instr_retired), 32'd7);

    run_instr(6'b101011, 0, 2, 1, a, b, c);
    #1 check("post_abort_retired", instr_retired, 32'd0);

    for (int i = 0; i < 16; i++) run_instr(6'b001000, i % 2, 0, 0, a, b, c);
    #1 check("addi16_retired", instr_retired, 32'd16);
    check("w4_wrap", 32'(w4_instr_retired), 32'd0);
    check("final_state", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
